// File: rtl/dynamic_output_rr_sched_if.sv
// Signal bundle between the input buffers, the output mux/link register and
// the round-robin wormhole scheduler of one dynamic-network output port.
interface dynamic_output_rr_sched_if #(
    parameter int CNT_WIDTH = 3
);
    logic                 route_req_0_in;
    logic                 route_req_1_in;
    logic                 valid_0_in;
    logic                 valid_1_in;
    logic                 tail_0_in;
    logic                 tail_1_in;
    logic                 yummy_in;
    logic                 current_route_out;
    logic                 valid_out;
    logic                 thanks_0_out;
    logic                 thanks_1_out;
    logic                 busy_out;
    logic [CNT_WIDTH-1:0] credit_cnt_out;
    logic                 ec_wants_to_send_but_cannot;
    logic                 credit_err_out;

    modport slave (
        input  route_req_0_in,
        input  route_req_1_in,
        input  valid_0_in,
        input  valid_1_in,
        input  tail_0_in,
        input  tail_1_in,
        input  yummy_in,
        output current_route_out,
        output valid_out,
        output thanks_0_out,
        output thanks_1_out,
        output busy_out,
        output credit_cnt_out,
        output ec_wants_to_send_but_cannot,
        output credit_err_out
    );

    modport master (
        output route_req_0_in,
        output route_req_1_in,
        output valid_0_in,
        output valid_1_in,
        output tail_0_in,
        output tail_1_in,
        output yummy_in,
        input  current_route_out,
        input  valid_out,
        input  thanks_0_out,
        input  thanks_1_out,
        input  busy_out,
        input  credit_cnt_out,
        input  ec_wants_to_send_but_cannot,
        input  credit_err_out
    );
endinterface

// File: rtl/dynamic_output_rr_sched.sv
// Two-input round-robin wormhole scheduler for one dynamic-network output
// port: holds a grant from head to tail and gates flits on downstream credits.
module dynamic_output_rr_sched #(
    parameter int CREDITS   = 4,
    parameter int CNT_WIDTH = 3
) (
    input logic                      clk,
    input logic                      rst_n,
    dynamic_output_rr_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTE_0 = 2'd1,
        ROUTE_1 = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CREDIT_MAX = CNT_WIDTH'(CREDITS);

    state_t               state_q, state_d;
    logic                 prio_q, prio_d;
    logic                 route_q, route_d;
    logic [CNT_WIDTH-1:0] credit_q, credit_d;
    logic                 err_q, err_d;

    logic req_0, req_1;
    logic credit_ok;
    logic grant_1;
    logic launch;
    logic pop_0, pop_1;
    logic stall;

    assign req_0     = bus.route_req_0_in & bus.valid_0_in;
    assign req_1     = bus.route_req_1_in & bus.valid_1_in;
    assign credit_ok = (credit_q != '0);
    assign grant_1   = req_1 & (~req_0 | prio_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            route_q  <= 1'b0;
            credit_q <= CREDIT_MAX;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            route_q  <= route_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    // On a tail only the other input is considered, since the granted input's
    // next head is not visible yet; that is what gives zero-gap alternation.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        route_d = route_q;
        launch  = 1'b0;
        pop_0   = 1'b0;
        pop_1   = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_0 | req_1) begin
                    route_d = grant_1;
                    state_d = grant_1 ? ROUTE_1 : ROUTE_0;
                end
            end
            ROUTE_0: begin
                launch = bus.valid_0_in & credit_ok;
                pop_0  = launch;
                stall  = bus.valid_0_in & ~credit_ok;
                if (launch & bus.tail_0_in) begin
                    prio_d = 1'b1;
                    if (req_1) begin
                        state_d = ROUTE_1;
                        route_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ROUTE_1: begin
                launch = bus.valid_1_in & credit_ok;
                pop_1  = launch;
                stall  = bus.valid_1_in & ~credit_ok;
                if (launch & bus.tail_1_in) begin
                    prio_d = 1'b0;
                    if (req_0) begin
                        state_d = ROUTE_0;
                        route_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A credit returned while already full is dropped and flagged stickily.
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        case ({launch, bus.yummy_in})
            2'b10: credit_d = credit_q - 1'b1;
            2'b01: begin
                if (credit_q == CREDIT_MAX) begin
                    err_d = 1'b1;
                end else begin
                    credit_d = credit_q + 1'b1;
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    assign bus.current_route_out           = route_q;
    assign bus.valid_out                   = launch;
    assign bus.thanks_0_out                = pop_0;
    assign bus.thanks_1_out                = pop_1;
    assign bus.busy_out                    = (state_q != IDLE);
    assign bus.credit_cnt_out              = credit_q;
    assign bus.ec_wants_to_send_but_cannot = stall;
    assign bus.credit_err_out              = err_q;
endmodule
